// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (div.w/div.wu/mod.w/mod.wu) for the execute stage.
// Accepts a request in IDLE, produces one quotient bit per cycle, and holds the result in DONE.
module iter_divider #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              is_flush,
  input  logic              is_stall,
  input  logic              en,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] div_mag_q;
  logic              q_neg_q;
  logic              r_neg_q;
  logic              div_zero_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W-1:0] dividend_mag;
  logic [DATA_W-1:0] divisor_mag;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff_lo;
  logic              trial_ok;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic              last_iter;

  // Magnitudes are only taken for signed operation; unsigned operands pass through raw.
  assign dividend_mag = (is_signed && dividend[DATA_W-1]) ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = (is_signed && divisor[DATA_W-1])  ? (~divisor + 1'b1)  : divisor;

  // Shifted partial remainder can reach 2*divisor, so it needs one extra bit.
  assign rem_sh    = {rem_q, quo_q[DATA_W-1]};
  assign trial_ok  = (rem_sh >= {1'b0, div_mag_q});
  assign diff_lo   = DATA_W'(rem_sh - {1'b0, div_mag_q});
  assign rem_nxt   = trial_ok ? diff_lo : rem_sh[DATA_W-1:0];
  assign quo_nxt   = {quo_q[DATA_W-2:0], trial_ok};
  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      done       <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_mag_q  <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
    end else if (is_flush) begin
      state_q <= StIdle;
      done    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            state_q    <= StCalc;
            rem_q      <= '0;
            quo_q      <= dividend_mag;
            div_mag_q  <= divisor_mag;
            q_neg_q    <= is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            r_neg_q    <= is_signed & dividend[DATA_W-1];
            div_zero_q <= (divisor == '0);
            cnt_q      <= '0;
          end
        end
        StCalc: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q <= StDone;
            done    <= 1'b1;
            // Divide-by-zero keeps the all-ones quotient; negating the remainder magnitude
            // restores the original dividend, so only the quotient fix-up is bypassed.
            quotient  <= (q_neg_q && !div_zero_q) ? (~quo_nxt + 1'b1) : quo_nxt;
            remainder <= r_neg_q ? (~rem_nxt + 1'b1) : rem_nxt;
          end
        end
        StDone: begin
          if (!is_stall) begin
            state_q <= StIdle;
            done    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: stimulus pushes expected results, a monitor checks
// result values, done latency, hold under stall, and done release/flush.
module tb_iter_divider;

  logic        clk;
  logic        rst_n;
  logic        is_flush;
  logic        is_stall;
  logic        en;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;

  iter_divider #(
    .DATA_W(32),
    .CNT_W (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .is_flush (is_flush),
    .is_stall (is_stall),
    .en       (en),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .done     (done)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          t_done;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic stall_e = 1'b0;
  logic flush_e = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    stall_e <= is_stall;
    flush_e <= is_flush;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops on each rising done, then checks hold/release on later cycles.
  initial begin
    exp_t cur;
    logic prev_done;
    prev_done = 1'b0;
    cur.q = '0;
    cur.r = '0;
    cur.t_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
      end else begin
        if (done && !prev_done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            cur = sb.pop_front();
            chk("done_latency", 32'(cyc), 32'(cur.t_done));
            chk("quotient", quotient, cur.q);
            chk("remainder", remainder, cur.r);
          end
        end else if (prev_done) begin
          if (flush_e || !stall_e) begin
            chk("done_release", 32'(done), 32'd0);
          end else begin
            chk("done_hold", 32'(done), 32'd1);
            chk("quotient_hold", quotient, cur.q);
            chk("remainder_hold", remainder, cur.r);
          end
        end
        prev_done = done;
      end
    end
  end

  // Issue one request, push its expectation, wait (bounded) for done.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic stall,
                          output bit seen);
    exp_t e;
    @(negedge clk);
    en        = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    is_stall  = stall;
    @(posedge clk);
    #1;
    e.q      = eq;
    e.r      = er;
    e.t_done = cyc + 32;
    sb.push_back(e);
    @(negedge clk);
    en        = 1'b0;
    is_signed = ~sgn;
    dividend  = ~a;
    divisor   = a ^ b;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      chk("done_timeout", 32'(seen), 32'd1);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int stall_n,
                        input logic flush_in_done);
    bit seen;
    start_op(sgn, a, b, eq, er, stall_n > 0, seen);
    if (seen) begin
      repeat (stall_n) @(negedge clk);
      if (flush_in_done) is_flush = 1'b1;
      else is_stall = 1'b0;
      @(negedge clk);
      is_flush = 1'b0;
      is_stall = 1'b0;
    end
  endtask

  initial begin
    bit seen;
    int c0;
    rst_n     = 1'b0;
    is_flush  = 1'b0;
    is_stall  = 1'b0;
    en        = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #3;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
    run_op(1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 0, 1'b0);
    run_op(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 0, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 1'b0);
    run_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 2, 1'b1);

    // Flush mid-CALC: the aborted op must never raise done; the next op is clean.
    @(negedge clk);
    en        = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(posedge clk);
    #1;
    c0 = cyc;
    @(negedge clk);
    en = 1'b0;
    while (cyc < c0 + 9) @(negedge clk);
    is_flush = 1'b1;
    @(negedge clk);
    is_flush = 1'b0;
    run_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 0, 1'b0);

    // en together with flush in IDLE is not accepted.
    @(negedge clk);
    en       = 1'b1;
    is_flush = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd1;
    @(negedge clk);
    en       = 1'b0;
    is_flush = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush_blocks_en", 32'(done), 32'd0);

    // Asynchronous reset while holding a result in DONE.
    start_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b1, seen);
    if (seen) begin
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_done", 32'(done), 32'd0);
      chk("async_reset_quotient", quotient, 32'd0);
      chk("async_reset_remainder", remainder, 32'd0);
      is_stall = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
    end
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("pending_results", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
